// File: rtl/phase_sequencer.sv
// phase_sequencer: five-phase instruction sequencer with run/stop/halt control and a single p5 register-file write strobe.
// Latency: p1 one cycle after an exec edge in IDLE; the instruction period is NUM_PHASE cycles; there are no stall inputs.
// Backpressure: none; the fields are sampled only in p2. Optional PHASE_SEQ_HALT_EN enables HLT decode and the HALT state.
module phase_sequencer #(
  parameter int NUM_PHASE = 5,
  parameter int REG_AW    = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 exec,
  input  logic [1:0]           op1,
  input  logic [REG_AW-1:0]    rd_rb,
  input  logic [REG_AW-1:0]    ra_op2,
  input  logic [3:0]           op3,
  output logic [NUM_PHASE-1:0] phase,
  output logic                 running,
  output logic                 halted,
  output logic                 reg_we,
  output logic [REG_AW-1:0]    reg_waddr
);

`ifdef PHASE_SEQ_HALT_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t state;

  // exec_q resets high so an exec level already present at reset release is not seen as an edge
  logic exec_q;
  logic exec_edge;
  logic stop_pend;
  logic wr_pend;
  logic dec_we;
  logic [REG_AW-1:0] dec_addr;
  logic [NUM_PHASE-1:0] phase_next;

  assign exec_edge  = exec & ~exec_q;
  assign phase_next = {phase[NUM_PHASE-2:0], phase[NUM_PHASE-1]};

`ifdef PHASE_SEQ_HALT_EN
  logic hlt_pend;
  logic dec_hlt;
  assign dec_hlt = (op1 == 2'b11) && (op3 == 4'd15);
`else
  assign halted = 1'b0;
`endif

  // Decode the instruction fields into a write decision and a destination address
  always_comb begin
    dec_we   = 1'b0;
    dec_addr = rd_rb;
    case (op1)
      2'b00: begin
        dec_we   = 1'b1;
        dec_addr = ra_op2;
      end
      2'b01: dec_we = 1'b0;
      2'b10: dec_we = (ra_op2 == REG_AW'(0)) || (ra_op2 == REG_AW'(1)) ||
                      (ra_op2 == REG_AW'(2)) || (ra_op2 == REG_AW'(6));
      default: begin
        case (op3)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6,
          4'd8, 4'd9, 4'd10, 4'd11, 4'd12: dec_we = 1'b1;
          default:                         dec_we = 1'b0;
        endcase
      end
    endcase
  end

  // Control FSM: phase rotation, run/stop/halt, p2 decode capture and the p5 write strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      exec_q    <= 1'b1;
      phase     <= '0;
      running   <= 1'b0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      stop_pend <= 1'b0;
      wr_pend   <= 1'b0;
`ifdef PHASE_SEQ_HALT_EN
      halted    <= 1'b0;
      hlt_pend  <= 1'b0;
`endif
    end else begin
      exec_q <= exec;
      case (state)
        S_IDLE: begin
          reg_we <= 1'b0;
          if (exec_edge) begin
            state   <= S_RUN;
            phase   <= NUM_PHASE'(1);
            running <= 1'b1;
          end
        end

        S_RUN: begin
          if (exec_edge) stop_pend <= 1'b1;
          // fields are captured only at the end of p2; later changes are ignored
          if (phase[1]) begin
            wr_pend   <= dec_we;
            reg_waddr <= dec_addr;
`ifdef PHASE_SEQ_HALT_EN
            hlt_pend  <= dec_hlt;
`endif
          end
          // strobe is registered at the end of p4 so it is high for exactly the p5 cycle
          reg_we <= wr_pend & phase[NUM_PHASE-2];
          if (phase[NUM_PHASE-1]) begin
            wr_pend   <= 1'b0;
            stop_pend <= 1'b0;
`ifdef PHASE_SEQ_HALT_EN
            hlt_pend  <= 1'b0;
            if (hlt_pend) begin
              // halt takes priority over a pending stop
              state   <= S_HALT;
              phase   <= '0;
              running <= 1'b0;
              halted  <= 1'b1;
            end else
`endif
            if (stop_pend || exec_edge) begin
              state   <= S_IDLE;
              phase   <= '0;
              running <= 1'b0;
            end else begin
              phase <= phase_next;
            end
          end else begin
            phase <= phase_next;
          end
        end

`ifdef PHASE_SEQ_HALT_EN
        S_HALT: begin
          reg_we <= 1'b0;
          if (exec_edge) begin
            state  <= S_IDLE;
            halted <= 1'b0;
          end
        end
`endif

        default: begin
          state   <= S_IDLE;
          phase   <= '0;
          running <= 1'b0;
          reg_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
